// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer, synchronous flush,
// control gating on invalid stages and a saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (CLR) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (in_fire) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        2'b10: begin
          if (out_fire && in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (out_fire) begin
            main_valid_d = 1'b0;
          end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end
        end
        2'b11: begin
          if (out_fire) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid-only occupancy is unreachable; fall back to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && stall_cnt_q != CntMax) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_skid;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 160;

  logic          clk, rst_n, clr, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_stall_cnt;

  pipe_stage_skid dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         mq[$];
  logic [DW-1:0] hold_data;
  int unsigned   raw_stall;
  int            ncmp = 0;
  int            nfail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hold_data = '0;
    raw_stall = 0;
  endtask

  task automatic check_all();
    logic [15:0] ec;
    ec = (mq.size() > 0) ? mq[0].ctrl : '0;
    chk("out_valid", 256'(out_valid), 256'(mq.size() > 0));
    chk("in_ready", 256'(in_ready), 256'(mq.size() < 2));
    chk("out_ctrl", 256'(out_ctrl), 256'(ec));
    chk("out_data", 256'(out_data), 256'((mq.size() > 0) ? mq[0].data : hold_data));
    chk("stall_cnt", 256'(stall_cnt), 256'((raw_stall > 65535) ? 65535 : raw_stall));
    chk("stall_cnt_sat", 256'(s_stall_cnt), 256'((raw_stall > 15) ? 15 : raw_stall));
    chk("sat_out_data", 256'(s_out_data), 256'(out_data));
  endtask

  // One clock: fires decided from pre-edge occupancy, model updated at the edge, checked after.
  task automatic cycle();
    bit    inf, outf;
    beat_t b;
    inf  = in_valid && (mq.size() < 2);
    outf = out_ready && (mq.size() > 0);
    b.ctrl = in_ctrl;
    b.data = in_data;
    if (mq.size() > 0 && !out_ready) raw_stall++;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      hold_data = '0;
    end else begin
      if (outf) begin
        hold_data = mq[0].data;
        void'(mq.pop_front());
      end
      if (inf) mq.push_back(b);
    end
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v, input logic r, input logic [CW-1:0] c,
                       input logic [DW-1:0] d);
    in_valid  = v;
    out_ready = r;
    in_ctrl   = c;
    in_data   = d;
  endtask

  logic [DW-1:0] da, db, dc;

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    model_reset();
    #1;
    check_all();
    chk("reset_in_ready", 256'(in_ready), 256'(1));
    #6 rst_n = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'hFFFF, DW'(i));
      cycle();
      chk("stream_data", 256'(out_data), 256'(i));
      chk("stream_ready", 256'(in_ready), 256'(1));
    end
    chk("stream_stall", 256'(stall_cnt), 256'(0));

    // Drain with no new input: ctrl gated, data held.
    drive(1'b0, 1'b1, '0, '0);
    cycle();
    chk("gate_ctrl", 256'(out_ctrl), 256'(0));
    chk("gate_data_hold", 256'(out_data), 256'(7));

    // Skid fill and release.
    da = rnd_data();
    db = rnd_data();
    drive(1'b1, 1'b1, 16'h0A0A, da);
    cycle();
    drive(1'b1, 1'b0, 16'h0B0B, db);
    cycle();
    chk("skid_in_ready", 256'(in_ready), 256'(0));
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) cycle();
    chk("skid_stall4", 256'(stall_cnt), 256'(4));
    chk("skid_hold_a", 256'(out_data), 256'(da));
    drive(1'b0, 1'b1, '0, '0);
    cycle();
    chk("skid_deliver_b", 256'(out_data), 256'(db));
    chk("skid_ready_back", 256'(in_ready), 256'(1));
    cycle();
    chk("skid_empty", 256'(out_valid), 256'(0));

    // Flush in TWO while a third beat is offered.
    dc = rnd_data();
    drive(1'b1, 1'b1, 16'h1111, rnd_data());
    cycle();
    drive(1'b1, 1'b0, 16'h2222, rnd_data());
    cycle();
    drive(1'b1, 1'b0, 16'h3333, dc);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("flush_valid", 256'(out_valid), 256'(0));
    chk("flush_ctrl", 256'(out_ctrl), 256'(0));
    chk("flush_ready", 256'(in_ready), 256'(1));
    drive(1'b0, 1'b1, '0, '0);
    repeat (3) begin
      cycle();
      chk("flush_no_c", 256'(out_valid), 256'(0));
    end

    // Long stall saturates the 4-bit counter; flush must not clear it.
    drive(1'b1, 1'b0, 16'h4444, rnd_data());
    cycle();
    drive(1'b0, 1'b0, '0, '0);
    repeat (20) cycle();
    chk("sat_15", 256'(s_stall_cnt), 256'(15));
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("sat_after_clr", 256'(s_stall_cnt), 256'(15));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            CW'($urandom()), rnd_data());
      clr = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clr = 1'b0;

    // Asynchronous reset in TWO, between clock edges.
    drive(1'b1, 1'b1, 16'h5555, rnd_data());
    cycle();
    drive(1'b1, 1'b0, 16'h6666, rnd_data());
    cycle();
    chk("pre_rst_two", 256'(in_ready), 256'(0));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", 256'(out_valid), 256'(0));
    chk("arst_data", 256'(out_data), 256'(0));
    #2 rst_n = 1'b1;
    da = rnd_data();
    drive(1'b1, 1'b1, 16'h7777, da);
    cycle();
    chk("post_rst_latency", 256'(out_data), 256'(da));
    chk("post_rst_valid", 256'(out_valid), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, flow-controlled pipeline stage register: the successor to the fixed-width, always-advancing stage registers between the core's pipeline stages. It carries one control vector and one data vector per instruction through a two-entry skid buffer with a valid/ready handshake on both sides. It adds a synchronous flush that turns the stage into a bubble, control gating so an invalid stage never asserts side-effect signals, and a saturating stall counter. Instances sit between Decode/Execute, Execute/Memory and Memory/Writeback.

## Interface
- CTRL_W, 16: width of control vector (RegWrite, MemWrite, Jump, Branch, ...); gated to 0 when stage invalid.
- DATA_W, 160: width of data vector (operands, PC, immediate, register indices, ...).
- CNT_W, 16: width of stall counter.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous flush; kills both buffer entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream data vector.
- out_valid  out  1  main entry holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  main control AND out_valid (per bit).
- out_data  out  DATA_W  main data, raw.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1, out_ready=0.

## Operation
- Storage: main entry (main_valid, main_ctrl, main_data) drives outputs; skid entry (skid_valid, skid_ctrl, skid_data) absorbs one beat when downstream stalls.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States by occupancy: EMPTY (main 0, skid 0), ONE (main 1, skid 0), TWO (main 1, skid 1). Skid-only is unreachable.
- EMPTY: in_fire -> main <= input, go ONE; else stay.
- ONE: out_fire & in_fire -> main <= input, stay ONE. out_fire & !in_fire -> go EMPTY. !out_fire & in_fire -> skid <= input, go TWO. Neither -> stay.
- TWO: in_ready=0, so no in_fire. out_fire -> main <= skid, skid_valid <= 0, go ONE; else stay.
- CLR (highest priority below reset): next state EMPTY; main_ctrl, skid_ctrl, main_data, skid_data <= 0. A beat presented with in_fire in the CLR cycle is dropped. An out_fire in the CLR cycle still counts as consumed downstream.
- out_ctrl is forced to 0 whenever out_valid=0. out_data is not gated and holds its last value.
- stall_cnt: +1 each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1 and is unaffected by CLR. Only reset clears it.
- Data is never reordered or duplicated. Every accepted beat leaves exactly once unless flushed.

## Timing
- Reset (RST_N=0, asynchronous assert): out_valid=0, in_ready=1, out_ctrl=0, out_data=0, stall_cnt=0, both entries cleared. Deassertion takes effect at the next rising CLK.
- Latency: a beat accepted at edge N is visible on out_* after edge N (one cycle) when the stage was EMPTY or ONE with out_fire.
- Throughput: one beat per cycle while out_ready=1 continuously.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- After out_ready drops, the stage accepts exactly one more beat; in_ready falls the cycle after.
- Flush: CLR asserted at edge N -> out_valid=0, out_ctrl=0, in_ready=1 after edge N.
- Reset mid-transfer: all state is lost immediately, including any skid contents.

## Test plan
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=0..7 -> out_data=0..7, each one cycle after acceptance; in_ready stays 1; stall_cnt=0.
- Skid fill: in state ONE (data A), drop out_ready while presenting B -> B goes to skid, in_ready=0 next cycle. Hold out_ready=0 3 cycles -> stall_cnt=4, out_data=A. Raise out_ready -> A then B delivered, in_ready=1 again.
- Flush in state TWO with CLR=1 while in_valid=1 (data C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears on the output.
- Control gating: main holds ctrl=16'hFFFF, then drains with no new input -> out_ctrl=0 while out_data keeps its last value.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15; a following CLR leaves stall_cnt=15.
- Asynchronous reset: assert RST_N=0 mid-cycle in state TWO -> outputs reach their reset values immediately, without waiting for a CLK edge; after release, the first beat takes the normal one-cycle latency.
